// File: rtl/murax_sw_debounce.sv
// Switch conditioner for the Murax GPIO-A read bus: per-bit 2-flop synchronizer, debounce counter, change pulse.
// Sticky event flags and io_irq are built only when GPIO_SW_EVENT_EN is defined; otherwise they are tied to 0.
module murax_sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             io_mainClk,
  input  logic             io_asyncReset,
  input  logic [WIDTH-1:0] io_sw_raw,
  output logic [WIDTH-1:0] io_sw_clean,
  output logic [WIDTH-1:0] io_sw_changed,
  input  logic [WIDTH-1:0] io_evt_clear,
  output logic [WIDTH-1:0] io_evt_pending,
  output logic             io_irq
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  logic [WIDTH-1:0]            r_stable;
  logic [WIDTH-1:0]            r_changed;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0]            w_accept;

  // A bit is accepted once sync2 has differed from the stable value for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    w_accept   = '0;
    w_cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_accept[i]   = 1'b1;
        w_cnt_next[i] = '0;
      end else begin
        w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_stable  <= '0;
      r_changed <= '0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= io_sw_raw;
      r_sync2   <= r_sync1;
      r_stable  <= r_stable ^ w_accept;
      r_changed <= w_accept;
      r_cnt     <= w_cnt_next;
    end
  end

  assign io_sw_clean   = r_stable;
  assign io_sw_changed = r_changed;

`ifdef GPIO_SW_EVENT_EN
  logic [WIDTH-1:0] r_pending;
  logic             r_irq;
  logic [WIDTH-1:0] w_pending_next;

  // A new change on the same cycle as its clear keeps the flag set.
  always_comb begin
    w_pending_next = (r_pending & ~io_evt_clear) | w_accept;
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_irq     <= |w_pending_next;
    end
  end

  assign io_evt_pending = r_pending;
  assign io_irq         = r_irq;
`else
  logic w_unused_evt_clear;

  assign w_unused_evt_clear = ^io_evt_clear;
  assign io_evt_pending     = '0;
  assign io_irq             = 1'b0;
`endif

endmodule

// File: tb/tb_murax_sw_debounce.sv
// Self-checking bench for murax_sw_debounce (WIDTH=16, DEBOUNCE_CYCLES=4): directed plan steps then random traffic.
// The reference model accepts a bit when the raw samples of the last DEBOUNCE_CYCLES synchronized edges all differ from it.
module tb_murax_sw_debounce;

  localparam int D = 4;
`ifdef GPIO_SW_EVENT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic        io_mainClk;
  logic        io_asyncReset;
  logic [15:0] io_sw_raw;
  logic [15:0] io_sw_clean;
  logic [15:0] io_sw_changed;
  logic [15:0] io_evt_clear;
  logic [15:0] io_evt_pending;
  logic        io_irq;

  murax_sw_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(D)) dut (
    .io_mainClk    (io_mainClk),
    .io_asyncReset (io_asyncReset),
    .io_sw_raw     (io_sw_raw),
    .io_sw_clean   (io_sw_clean),
    .io_sw_changed (io_sw_changed),
    .io_evt_clear  (io_evt_clear),
    .io_evt_pending(io_evt_pending),
    .io_irq        (io_irq)
  );

  initial io_mainClk = 1'b0;
  always #5 io_mainClk = ~io_mainClk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model state: raw values sampled at each edge since reset, newest first.
  logic [15:0] hist[$];
  logic [15:0] m_stable;
  logic [15:0] m_changed;
  logic [15:0] m_pend;
  logic        m_irq;

  function automatic logic [15:0] hget(int i);
    return (i < hist.size()) ? hist[i] : 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_stable  = 16'h0000;
    m_changed = 16'h0000;
    m_pend    = 16'h0000;
    m_irq     = 1'b0;
  endtask

  // Drive at the falling edge, let one rising edge happen, update the model, check 1 ns later.
  task automatic step(input logic [15:0] raw, input logic [15:0] clr);
    io_sw_raw    = raw;
    io_evt_clear = clr;
    @(posedge io_mainClk);
    hist.push_front(raw);
    if (hist.size() > 16) void'(hist.pop_back());
    // sync2 at this edge holds the raw value sampled two edges earlier (hist[2]).
    m_changed = 16'hFFFF;
    for (int j = 0; j < D; j++) m_changed &= hget(2 + j) ^ m_stable;
    m_stable = m_stable ^ m_changed;
    if (EVT_EN) begin
      m_pend = (m_pend & ~clr) | m_changed;
      m_irq  = |m_pend;
    end
    #1;
    check("clean",   io_sw_clean,    m_stable);
    check("changed", io_sw_changed,  m_changed);
    check("pending", io_evt_pending, m_pend);
    check("irq",     {15'h0000, io_irq}, {15'h0000, m_irq});
    @(negedge io_mainClk);
  endtask

  logic [15:0] cur;
  logic [15:0] drv;
  logic [15:0] clr;

  initial begin
    io_asyncReset = 1'b1;
    io_sw_raw     = 16'h0000;
    io_evt_clear  = 16'h0000;
    model_reset();

    // Reset state while held.
    repeat (3) @(posedge io_mainClk);
    #1;
    check("rst_clean",   io_sw_clean,    16'h0000);
    check("rst_changed", io_sw_changed,  16'h0000);
    check("rst_pending", io_evt_pending, 16'h0000);
    check("rst_irq",     {15'h0000, io_irq}, 16'h0000);
    @(negedge io_mainClk);
    io_asyncReset = 1'b0;

    // Quiet inputs after reset release.
    repeat (20) step(16'h0000, 16'h0000);

    // Single bit rise: accepted on the sixth edge counting the capturing edge.
    for (int s = 1; s <= 8; s++) begin
      step(16'h0001, 16'h0000);
      if (s == 5) check("rise_early",   io_sw_clean,   16'h0000);
      if (s == 6) check("rise_clean",   io_sw_clean,   16'h0001);
      if (s == 6) check("rise_pulse",   io_sw_changed, 16'h0001);
      if (s == 7) check("rise_one_cyc", io_sw_changed, 16'h0000);
    end
    repeat (8) step(16'h0000, 16'h0000);
    check("fall_clean", io_sw_clean, 16'h0000);

    // Three-cycle glitch is filtered out.
    repeat (3) step(16'h0004, 16'h0000);
    for (int s = 1; s <= 8; s++) begin
      step(16'h0000, 16'h0000);
      check("glitch3_clean",   io_sw_clean,   16'h0000);
      check("glitch3_changed", io_sw_changed, 16'h0000);
    end

    // Four-cycle pulse is accepted, then its release is accepted.
    repeat (4) step(16'h0004, 16'h0000);
    for (int s = 5; s <= 12; s++) begin
      step(16'h0000, 16'h0000);
      if (s == 6)  check("pulse4_clean",    io_sw_clean,   16'h0004);
      if (s == 10) check("pulse4_release",  io_sw_changed, 16'h0004);
      if (s == 10) check("pulse4_back",     io_sw_clean,   16'h0000);
    end

    // Multi-bit simultaneous change.
    for (int s = 1; s <= 8; s++) begin
      step(16'hA5A5, 16'h0000);
      if (s == 6) check("multi_clean",   io_sw_clean,   16'hA5A5);
      if (s == 6) check("multi_changed", io_sw_changed, 16'hA5A5);
    end

    // Asynchronous reset mid-count drops the clean value at once.
    repeat (2) step(16'hFFFF, 16'h0000);
    check("pre_rst_clean", io_sw_clean, 16'hA5A5);
    #2;
    io_asyncReset = 1'b1;
    #1;
    check("async_rst_clean",   io_sw_clean,   16'h0000);
    check("async_rst_changed", io_sw_changed, 16'h0000);
    repeat (2) @(posedge io_mainClk);
    @(negedge io_mainClk);
    io_asyncReset = 1'b0;
    model_reset();
    for (int s = 1; s <= 8; s++) begin
      step(16'hFFFF, 16'h0000);
      if (s == 5) check("post_rst_early", io_sw_clean,   16'h0000);
      if (s == 6) check("post_rst_clean", io_sw_clean,   16'hFFFF);
      if (s == 6) check("post_rst_pulse", io_sw_changed, 16'hFFFF);
    end

    // Event flags: set, set-beats-clear, clear alone.
    step(16'hFFFF, 16'hFFFF);
    for (int s = 1; s <= 8; s++) begin
      step(16'hFFF7, 16'h0000);
      if (s == 6) check("evt_set_pending", io_evt_pending, EVT_EN ? 16'h0008 : 16'h0000);
      if (s == 6) check("evt_set_irq", {15'h0000, io_irq}, EVT_EN ? 16'h0001 : 16'h0000);
    end
    repeat (5) step(16'hFFFF, 16'h0000);
    step(16'hFFFF, 16'h0008);
    check("evt_setwins_changed", io_sw_changed,  16'h0008);
    check("evt_setwins_pending", io_evt_pending, EVT_EN ? 16'h0008 : 16'h0000);
    step(16'hFFFF, 16'h0008);
    check("evt_clear_pending", io_evt_pending, 16'h0000);
    check("evt_clear_irq", {15'h0000, io_irq}, 16'h0000);

    // Random traffic: held flips, single-cycle glitches, random clears.
    cur = 16'hFFFF;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) cur = cur ^ 16'($urandom);
      drv = cur;
      if (r == 1) drv = cur ^ 16'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0000;
      step(drv, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
